bus_sim_mem: RTL and testbench
==============================

Name: bus_sim_mem

Overview:
Parametrised simulation memory and run controller attached to the CPU external bus (a, d, oe, we; oe and we active-low).
- Serves reads and synchronous writes from an internal array.
- Detects run termination: finish-address access, cycle timeout, or bus conflict.
- Exposes a memory-mapped console byte stream through a small FIFO with valid/ready handshake.
- Used by CPU-level benches in place of a flat RAM array plus ad-hoc loop logic.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, bus data width
DEPTH, 65536, implemented words, ≤ 2**ADDR_W
INIT_FILE, "", hex image loaded with $readmemh at time 0 if non-empty
FINISH_ADDR, 16'h1000, address whose read ends the run
CONSOLE_ADDR, 16'hFF00, write-only console register address
MAX_CYCLES, 1000, run-cycle limit
CYC_W, 32, cycle counter width
CON_DEPTH, 16, console FIFO depth, power of two ≥ 2
ROM_TOP, 16'h0800, first writable address (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset (see Behaviour)
a  in  ADDR_W  bus address
d  inout  DATA_W  bus data
oe  in  1  output enable, active-low
we  in  1  write enable, active-low
done  out  1  run ended
status  out  2  0 RUN, 1 FINISH, 2 TIMEOUT, 3 CONFLICT
cycles  out  CYC_W  clocks spent in RUN
wr_count  out  CYC_W  accepted memory writes
con_data  out  DATA_W  console FIFO head
con_valid  out  1  head valid
con_ready  in  1  consumer accepts head
con_overflow  out  1  sticky; a console write was dropped
rom_faults  out  CYC_W  rejected ROM writes (ROM_PROTECT only)

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- While rst is high at a rising edge, the following are cleared:
  - done=0, status=RUN, cycles=0, wr_count=0, rom_faults=0.
  - Console FIFO emptied, so con_valid=0; con_overflow=0.
- Memory contents are not cleared by reset. Reset mid-run restarts the counters from zero.

Reads:
- d is driven combinationally with mem[a] when oe=0 and we=1; otherwise d is high-Z.
- a ≥ DEPTH reads 0. a==CONSOLE_ADDR reads the current FIFO occupancy, zero-extended.
- Reads are served in every state.

Writes:
- A write takes effect at the rising clk edge when we=0, oe=1 and state==RUN.
- a==CONSOLE_ADDR: push d into the FIFO; the memory array is untouched.
- a < DEPTH: mem[a]<=d and wr_count+1.
- a ≥ DEPTH: ignored.
- Writes in a terminal state are ignored.

Run FSM, evaluated each rising edge in RUN, first match wins:
1. oe=0 and we=0 → CONFLICT.
2. oe=0 and a==FINISH_ADDR → FINISH.
3. cycles==MAX_CYCLES-1 → TIMEOUT.
4. Otherwise stay in RUN, cycles+1.
- Entering any terminal state sets done=1 in the same edge. cycles freezes; the transition cycle is not counted.
- Terminal states hold until rst.

Console FIFO:
- Push latency: con_valid rises at the edge after the push.
- Pop: on con_valid & con_ready at an edge, the head is removed.
- Push when full is dropped and sets con_overflow, unless a pop happens in the same cycle; then the push is accepted.
- Push and pop on an empty FIFO: the push is accepted and no pop occurs.
- Pointers wrap modulo CON_DEPTH.
- con_data is stable while con_valid=1 and no pop occurs.

Optional Feature:
BUS_SIM_MEM_ROM_PROTECT_EN
- Defined: writes with a < ROM_TOP leave memory unchanged, do not bump wr_count, and increment rom_faults. Console writes are exempt.
- Undefined: all a < DEPTH are writable; rom_faults is tied to 0.

Decomposition:
- Package bus_sim_pkg holds the status encoding constants (ST_RUN, ST_FINISH, ST_TIMEOUT, ST_CONFLICT) and the 2-bit status typedef.
- One sub-module, bus_sim_con_fifo: parametrised DATA_W/CON_DEPTH synchronous FIFO with push/full/overflow and valid/ready pop.

Test Plan:
- Image with the program jumping to 0x1000: oe=0, a=0x1000 at cycle N → done=1, status=1, cycles=N on the next edge.
- Endless loop, MAX_CYCLES=50 → status=2, done=1 after 50 RUN clocks; cycles=49.
- Write 0x41, 0x42 to 0xFF00 with con_ready=0 → con_valid=1, con_data=0x41. Raise con_ready → 0x42 follows, then con_valid=0.
- 17 console writes with CON_DEPTH=16, con_ready=0 → 16 bytes retained, con_overflow=1. Full FIFO plus pop and push in one cycle → no overflow.
- oe=0 and we=0 on the same edge → status=3. Assert rst mid-run → status=0, cycles=0, memory contents kept.
- With BUS_SIM_MEM_ROM_PROTECT_EN defined, write 0x55 to 0x0010 → mem unchanged, rom_faults=1, wr_count=0. The same write to 0x0900 → accepted.

Source files
------------

// File: rtl/bus_sim_mem_pkg.sv
// Shared status encoding for the simulation memory / run controller.
package bus_sim_pkg;
  typedef logic [1:0] status_t;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FINISH   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_CONFLICT = 2'd3;
endpackage

// File: rtl/bus_sim_mem_if.sv
// CPU external bus control/address group (oe/we active-low); data stays a plain inout.
interface bus_sim_mem_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] a;
  logic              oe;
  logic              we;

  modport master (output a, oe, we);
  modport slave  (input  a, oe, we);
endinterface

// File: rtl/bus_sim_con_fifo.sv
// Console byte FIFO: push with drop-on-full (sticky overflow), valid/ready pop.
module bus_sim_con_fifo #(
  parameter int DATA_W    = 8,
  parameter int CON_DEPTH = 16,
  parameter int LVL_W     = $clog2(CON_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] head,
  output logic              valid,
  output logic              overflow,
  output logic [LVL_W-1:0]  level
);
  localparam int PW = $clog2(CON_DEPTH);

  logic [DATA_W-1:0] fifo_mem [CON_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  cnt;
  logic              full, pop, push_ok;

  assign valid   = (cnt != '0);
  assign full    = (cnt == LVL_W'(CON_DEPTH));
  assign pop     = valid & pop_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = push & (~full | pop);
  assign head    = fifo_mem[rd_ptr];
  assign level   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push & ~push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + LVL_W'(1);
        2'b01:   cnt <= cnt - LVL_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
endmodule

// File: rtl/bus_sim_mem.sv
// Simulation memory + run controller on the CPU bus, with a console FIFO.
// Optional BUS_SIM_MEM_ROM_PROTECT_EN rejects writes below ROM_TOP and counts them.
module bus_sim_mem
  import bus_sim_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 65536,
  parameter string             INIT_FILE    = "",
  parameter logic [ADDR_W-1:0] FINISH_ADDR  = 16'h1000,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 16'hFF00,
  parameter int                MAX_CYCLES   = 1000,
  parameter int                CYC_W        = 32,
  parameter int                CON_DEPTH    = 16,
  parameter logic [ADDR_W-1:0] ROM_TOP      = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  bus_sim_mem_if.slave      bus,
  inout  wire  [DATA_W-1:0] d,
  output logic              done,
  output status_t           status,
  output logic [CYC_W-1:0]  cycles,
  output logic [CYC_W-1:0]  wr_count,
  output logic [DATA_W-1:0] con_data,
  output logic              con_valid,
  input  logic              con_ready,
  output logic              con_overflow,
  output logic [CYC_W-1:0]  rom_faults
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(CON_DEPTH) + 1;
`ifdef BUS_SIM_MEM_ROM_PROTECT_EN
  localparam bit ROM_EN = 1'b1;
`else
  localparam bit ROM_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  status_t           state;
  logic [LVL_W-1:0]  con_level;
  logic [DATA_W-1:0] rd_data;
  logic in_range, is_con, running, wr_act, rd_act, rom_hit, mem_wr, rom_rej, con_push;

  assign in_range = (32'(bus.a) < 32'(DEPTH));
  assign is_con   = (bus.a == CONSOLE_ADDR);
  assign running  = (state == ST_RUN);
  assign wr_act   = ~bus.we & bus.oe & running;
  assign rd_act   = ~bus.oe & bus.we;
  assign rom_hit  = ROM_EN & (bus.a < ROM_TOP);
  assign con_push = wr_act & is_con;
  assign mem_wr   = wr_act & ~is_con & in_range & ~rom_hit;
  assign rom_rej  = wr_act & ~is_con & in_range & rom_hit;

  // console register shadows the array: reads return FIFO occupancy
  always_comb begin
    rd_data = '0;
    if (is_con)        rd_data = DATA_W'(con_level);
    else if (in_range) rd_data = mem[bus.a[AW-1:0]];
  end

  assign d = rd_act ? rd_data : {DATA_W{1'bz}};

  always_ff @(posedge clk)
    if (mem_wr) mem[bus.a[AW-1:0]] <= d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      cycles     <= '0;
      wr_count   <= '0;
      rom_faults <= '0;
    end else begin
      if (running) begin
        if (~bus.oe & ~bus.we)                    state  <= ST_CONFLICT;
        else if (~bus.oe & (bus.a == FINISH_ADDR)) state  <= ST_FINISH;
        else if (cycles == CYC_W'(MAX_CYCLES - 1)) state  <= ST_TIMEOUT;
        else                                       cycles <= cycles + CYC_W'(1);
      end
      if (mem_wr)  wr_count   <= wr_count + CYC_W'(1);
      if (rom_rej) rom_faults <= rom_faults + CYC_W'(1);
    end
  end

  assign done   = (state != ST_RUN);
  assign status = state;

  bus_sim_con_fifo #(
    .DATA_W   (DATA_W),
    .CON_DEPTH(CON_DEPTH),
    .LVL_W    (LVL_W)
  ) u_con (
    .clk      (clk),
    .rst      (rst),
    .push     (con_push),
    .push_data(d),
    .pop_ready(con_ready),
    .head     (con_data),
    .valid    (con_valid),
    .overflow (con_overflow),
    .level    (con_level)
  );
endmodule

// File: tb/tb_bus_sim_mem.sv
// Directed bench for bus_sim_mem: reads/writes, finish/timeout/conflict, console FIFO, ROM option.
module tb_bus_sim_mem;
  import bus_sim_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_sim_mem_if #(.ADDR_W(16)) bif ();
  logic [7:0]  d_drv;
  logic        d_en;
  wire  [7:0]  d;
  assign d = d_en ? d_drv : 8'hzz;

  logic        done, con_valid, con_ready, con_overflow;
  status_t     status;
  logic [31:0] cycles, wr_count, rom_faults;
  logic [7:0]  con_data;

  bus_sim_mem #(
    .DEPTH     (32768),
    .MAX_CYCLES(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .d           (d),
    .done        (done),
    .status      (status),
    .cycles      (cycles),
    .wr_count    (wr_count),
    .con_data    (con_data),
    .con_valid   (con_valid),
    .con_ready   (con_ready),
    .con_overflow(con_overflow),
    .rom_faults  (rom_faults)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bif.a = addr; d_drv = data; d_en = 1'b1; bif.oe = 1'b1; bif.we = 1'b0;
    tick();
    bif.we = 1'b1; d_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [7:0] v);
    bif.a = addr; bif.oe = 1'b0;
    #1 v = d;
    bif.oe = 1'b1;
    #1;
  endtask

  logic [7:0] v, base;

  initial begin
    bif.a = '0; bif.oe = 1'b1; bif.we = 1'b1;
    d_drv = '0; d_en = 1'b0; con_ready = 1'b0;
    tick(); tick();
    chk("rst_done", done, 0);
    chk("rst_status", status, ST_RUN);
    chk("rst_cycles", cycles, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_con_valid", con_valid, 0);
    chk("rst_overflow", con_overflow, 0);
    chk("rst_rom_faults", rom_faults, 0);
    rst = 1'b0;

    // plain reads/writes and console handshake
    wr(16'h0900, 8'h5A);
    rd(16'h0900, v);   chk("rd_0900", v, 8'h5A);
    chk("wr_count_1", wr_count, 1);
    wr(16'h9000, 8'h11);
    chk("wr_oob_ignored", wr_count, 1);
    rd(16'h9000, v);   chk("rd_oob_zero", v, 8'h00);
    chk("d_hiz", {31'b0, d === 8'hzz}, 1);
    wr(16'hFF00, 8'h41);
    chk("con_valid_1", con_valid, 1);
    chk("con_data_41", con_data, 8'h41);
    wr(16'hFF00, 8'h42);
    rd(16'hFF00, v);   chk("con_level_2", v, 8'd2);
    chk("con_data_stable", con_data, 8'h41);
    chk("con_not_mem_write", wr_count, 1);
    con_ready = 1'b1;
    tick();
    chk("con_pop_valid", con_valid, 1);
    chk("con_data_42", con_data, 8'h42);
    tick();
    chk("con_empty", con_valid, 0);
    con_ready = 1'b0;
    chk("cycles_6", cycles, 6);

    // finish address read
    bif.a = 16'h1000; bif.oe = 1'b0;
    tick();
    bif.oe = 1'b1;
    chk("fin_done", done, 1);
    chk("fin_status", status, ST_FINISH);
    chk("fin_cycles", cycles, 6);
    wr(16'h0900, 8'h77);
    rd(16'h0900, v);   chk("term_wr_ignored", v, 8'h5A);
    chk("term_wr_count", wr_count, 1);
    chk("term_cycles_frozen", cycles, 6);

    // reset keeps memory; FIFO fill, full push+pop, overflow, drain
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_status", status, ST_RUN);
    chk("rst2_cycles", cycles, 0);
    chk("rst2_wr_count", wr_count, 0);
    chk("rst2_con_valid", con_valid, 0);
    rd(16'h0900, v);   chk("mem_kept", v, 8'h5A);
    for (int i = 0; i < 16; i++) wr(16'hFF00, 8'(8'h10 + i));
    rd(16'hFF00, v);   chk("con_full_16", v, 8'd16);
    chk("full_no_ovf", con_overflow, 0);
    chk("full_head", con_data, 8'h10);
    con_ready = 1'b1;
    wr(16'hFF00, 8'h20);
    con_ready = 1'b0;
    chk("push_pop_no_ovf", con_overflow, 0);
    rd(16'hFF00, v);   chk("push_pop_level", v, 8'd16);
    chk("push_pop_head", con_data, 8'h11);
    wr(16'hFF00, 8'h21);
    chk("ovf_set", con_overflow, 1);
    rd(16'hFF00, v);   chk("ovf_level", v, 8'd16);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", con_data, 32'(8'h11 + i));
      tick();
    end
    con_ready = 1'b0;
    chk("drain_empty", con_valid, 0);
    chk("ovf_sticky", con_overflow, 1);
    chk("cycles_34", cycles, 34);

    // bus conflict, then reset mid-run
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    bif.a = 16'h0900; bif.oe = 1'b0; bif.we = 1'b0;
    tick();
    bif.oe = 1'b1; bif.we = 1'b1;
    chk("cfl_status", status, ST_CONFLICT);
    chk("cfl_done", done, 1);
    chk("cfl_cycles", cycles, 2);
    tick();
    chk("cfl_hold", status, ST_CONFLICT);
    rd(16'h0900, v);   chk("cfl_mem_intact", v, 8'h5A);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst3_status", status, ST_RUN);
    chk("rst3_done", done, 0);
    chk("rst3_cycles", cycles, 0);

    // timeout after MAX_CYCLES RUN clocks
    repeat (49) tick();
    chk("pre_to_status", status, ST_RUN);
    chk("pre_to_cycles", cycles, 49);
    tick();
    chk("to_status", status, ST_TIMEOUT);
    chk("to_done", done, 1);
    chk("to_cycles", cycles, 49);
    tick();
    chk("to_hold", status, ST_TIMEOUT);
    chk("to_cycles_hold", cycles, 49);

    // low-address write: rejected only with ROM protection
    rst = 1'b1; tick(); rst = 1'b0;
`ifdef BUS_SIM_MEM_ROM_PROTECT_EN
    rd(16'h0010, base);
    wr(16'h0010, 8'h55);
    rd(16'h0010, v);   chk("rom_unchanged", {31'b0, v === base}, 1);
    chk("rom_faults_1", rom_faults, 1);
    chk("rom_wr_count_0", wr_count, 0);
    wr(16'h0900, 8'h55);
    rd(16'h0900, v);   chk("ram_wr_0900", v, 8'h55);
    chk("ram_wr_count_1", wr_count, 1);
    chk("rom_faults_still_1", rom_faults, 1);
    wr(16'hFF00, 8'h99);
    chk("rom_con_exempt", con_valid, 1);
    chk("rom_con_no_fault", rom_faults, 1);
`else
    wr(16'h0010, 8'h55);
    rd(16'h0010, v);   chk("low_wr_ok", v, 8'h55);
    chk("low_rom_faults_0", rom_faults, 0);
    chk("low_wr_count_1", wr_count, 1);
    wr(16'h0900, 8'h55);
    rd(16'h0900, v);   chk("ram_wr_0900", v, 8'h55);
    chk("ram_wr_count_2", wr_count, 2);
    wr(16'hFF00, 8'h99);
    chk("con_valid_late", con_valid, 1);
    chk("rom_faults_zero", rom_faults, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
